// File: rtl/ex_pkg.sv
// Shared definitions for the MIPS execute stage: widths, ALU opcodes,
// R-type function codes, multiplier FSM states and a magnitude helper.
package ex_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  // Non-R-type ALU opcodes (EX_ALUop)
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b100;
  localparam logic [2:0] ALU_SLTU = 3'b101;
  localparam logic [2:0] ALU_LUI  = 3'b110;
  localparam logic [2:0] ALU_ADD2 = 3'b111;

  // R-type function codes (EX_func)
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;

  typedef enum logic [1:0] {
    M_IDLE,
    M_BUSY,
    M_DONE
  } mult_state_e;

  // Two's-complement magnitude when the operand is treated as signed
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x,
                                                input logic              sgn);
    return (sgn && x[DATA_W-1]) ? -x : x;
  endfunction

endpackage

// File: rtl/ex_stage_mult.sv
// Iterative shift-add multiplier with HI/LO result registers.
// Signed operands are multiplied as magnitudes and the product is negated
// at the final step when the operand signs differ.
module mult_unit
  import ex_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              stall,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int unsigned     CNT_W = $clog2(MULT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MULT_CYCLES - 1);

  mult_state_e         state_q, state_d;
  logic [CNT_W-1:0]    count_q;
  logic [DATA_W-1:0]   mcand_q;
  logic [2*DATA_W-1:0] prod_q;
  logic                neg_q;
  logic [DATA_W-1:0]   hi_q, lo_q;

  logic [DATA_W:0]     sum;
  logic [2*DATA_W-1:0] prod_next, prod_final;

  // Upper half accumulates the multiplicand; the whole product shifts right
  assign sum        = {1'b0, prod_q[2*DATA_W-1:DATA_W]} +
                      {1'b0, (prod_q[0] ? mcand_q : '0)};
  assign prod_next  = {sum, prod_q[DATA_W-1:1]};
  assign prod_final = neg_q ? -prod_next : prod_next;

  assign hi = hi_q;
  assign lo = lo_q;

  // Next-state and stall request
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      M_IDLE: begin
        if (start) begin
          stall   = 1'b1;
          state_d = M_BUSY;
        end
      end
      M_BUSY: begin
        stall = 1'b1;
        if (count_q == LAST) state_d = M_DONE;
      end
      M_DONE:  state_d = M_IDLE;
      default: state_d = M_IDLE;
    endcase
  end

  // State register, operand capture, iteration and HI/LO write
  always_ff @(negedge clk) begin
    if (rst) begin
      state_q <= M_IDLE;
      count_q <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        M_IDLE: begin
          if (start) begin
            mcand_q <= abs_val(a, signed_op);
            prod_q  <= {{DATA_W{1'b0}}, abs_val(b, signed_op)};
            neg_q   <= signed_op & (a[DATA_W-1] ^ b[DATA_W-1]);
            count_q <= '0;
          end
        end
        M_BUSY: begin
          prod_q  <= prod_next;
          count_q <= count_q + CNT_W'(1);
          if (count_q == LAST) {hi_q, lo_q} <= prod_final;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU control + ALU, immediate extension, branch/jump
// resolution, multiplier with HI/LO, and the EX/MEM pipeline register.
// Optional operand forwarding is enabled by defining EX_FWD_EN.
module ex_stage
  import ex_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [DATA_W-1:0] EX_PC4,
  input  logic [DATA_W-1:0] EX_Jtarg,
  input  logic [DATA_W-1:0] EX_busA,
  input  logic [DATA_W-1:0] EX_busB,
  input  logic [REG_W-1:0]  EX_Rt,
  input  logic [REG_W-1:0]  EX_Rd,
  input  logic [5:0]        EX_func,
  input  logic [15:0]       EX_immd,
  input  logic              EX_RegWr,
  input  logic              EX_ALUSrc,
  input  logic              EX_RegDst,
  input  logic              EX_MemtoReg,
  input  logic              EX_MemWr,
  input  logic              EX_Branch,
  input  logic              EX_Jump,
  input  logic              EX_ExtOp,
  input  logic              EX_R_type,
  input  logic [2:0]        EX_ALUop,
`ifdef EX_FWD_EN
  input  logic [REG_W-1:0]  EX_Rs,
  input  logic [REG_W-1:0]  WB_Rw,
  input  logic              WB_RegWr,
  input  logic [DATA_W-1:0] WB_busW,
`endif
  output logic              PCSrc,
  output logic [DATA_W-1:0] NextPC,
  output logic              Flush,
  output logic              Stall,
  output logic [DATA_W-1:0] MEM_ALUout,
  output logic [DATA_W-1:0] MEM_busB,
  output logic [REG_W-1:0]  MEM_Rw,
  output logic              MEM_RegWr,
  output logic              MEM_MemtoReg,
  output logic              MEM_MemWr
);

  logic [DATA_W-1:0] op_a, op_b, imm_sext, imm_ext, alu_b, alu_res, br_target;
  logic [DATA_W-1:0] hi, lo;
  logic              func_ok, is_mult, br_taken, slt_s, slt_u;

  logic [DATA_W-1:0] aluout_q, aluout_d, busb_q, busb_d;
  logic [REG_W-1:0]  rw_q, rw_d;
  logic              regwr_q, regwr_d, memtoreg_q, memtoreg_d, memwr_q, memwr_d;

`ifdef EX_FWD_EN
  // Operand bypass: the EX/MEM result is younger, so it wins over MEM/WB
  always_comb begin
    op_a = EX_busA;
    op_b = EX_busB;
    if (regwr_q && rw_q != '0 && rw_q == EX_Rs)        op_a = aluout_q;
    else if (WB_RegWr && WB_Rw != '0 && WB_Rw == EX_Rs) op_a = WB_busW;
    if (regwr_q && rw_q != '0 && rw_q == EX_Rt)        op_b = aluout_q;
    else if (WB_RegWr && WB_Rw != '0 && WB_Rw == EX_Rt) op_b = WB_busW;
  end
`else
  assign op_a = EX_busA;
  assign op_b = EX_busB;
`endif

  assign imm_sext = {{(DATA_W-16){EX_immd[15]}}, EX_immd};
  assign imm_ext  = EX_ExtOp ? imm_sext : {{(DATA_W-16){1'b0}}, EX_immd};
  assign alu_b    = EX_ALUSrc ? imm_ext : op_b;
  assign slt_s    = $signed(op_a) < $signed(alu_b);
  assign slt_u    = op_a < alu_b;
  assign is_mult  = EX_R_type && (EX_func == F_MULT || EX_func == F_MULTU);

  // ALU control decode and result select
  always_comb begin
    alu_res = '0;
    func_ok = 1'b1;
    if (EX_R_type) begin
      case (EX_func)
        F_ADD, F_ADDU:   alu_res = op_a + alu_b;
        F_SUB, F_SUBU:   alu_res = op_a - alu_b;
        F_AND:           alu_res = op_a & alu_b;
        F_OR:            alu_res = op_a | alu_b;
        F_SLT:           alu_res = {{(DATA_W-1){1'b0}}, slt_s};
        F_SLTU:          alu_res = {{(DATA_W-1){1'b0}}, slt_u};
        F_MFHI:          alu_res = hi;
        F_MFLO:          alu_res = lo;
        F_MULT, F_MULTU: alu_res = '0;
        default:         func_ok = 1'b0;
      endcase
    end else begin
      case (EX_ALUop)
        ALU_ADD, ALU_ADD2: alu_res = op_a + alu_b;
        ALU_SUB:           alu_res = op_a - alu_b;
        ALU_OR:            alu_res = op_a | alu_b;
        ALU_AND:           alu_res = op_a & alu_b;
        ALU_SLT:           alu_res = {{(DATA_W-1){1'b0}}, slt_s};
        ALU_SLTU:          alu_res = {{(DATA_W-1){1'b0}}, slt_u};
        ALU_LUI:           alu_res = {alu_b[15:0], 16'h0000};
        default:           alu_res = '0;
      endcase
    end
  end

  // Branch/jump resolution; jump overrides branch
  assign br_target = EX_PC4 + {imm_sext[DATA_W-3:0], 2'b00};
  assign br_taken  = EX_Branch && (op_a == op_b);
  assign PCSrc     = br_taken | EX_Jump;
  assign Flush     = PCSrc;
  assign NextPC    = EX_Jump ? EX_Jtarg : br_target;

  mult_unit #(
    .MULT_CYCLES (MULT_CYCLES)
  ) u_mult (
    .clk       (Clk),
    .rst       (Rst),
    .start     (is_mult),
    .signed_op (EX_func == F_MULT),
    .a         (op_a),
    .b         (op_b),
    .stall     (Stall),
    .hi        (hi),
    .lo        (lo)
  );

  // EX/MEM next value: a bubble while stalled or while a multiply holds EX
  always_comb begin
    aluout_d   = '0;
    busb_d     = '0;
    rw_d       = '0;
    regwr_d    = 1'b0;
    memtoreg_d = 1'b0;
    memwr_d    = 1'b0;
    if (!(Stall || is_mult)) begin
      aluout_d   = alu_res;
      busb_d     = op_b;
      rw_d       = EX_RegDst ? EX_Rd : EX_Rt;
      regwr_d    = EX_RegWr & func_ok;
      memtoreg_d = EX_MemtoReg;
      memwr_d    = EX_MemWr;
    end
  end

  // EX/MEM pipeline register
  always_ff @(negedge Clk) begin
    if (Rst) begin
      aluout_q   <= '0;
      busb_q     <= '0;
      rw_q       <= '0;
      regwr_q    <= 1'b0;
      memtoreg_q <= 1'b0;
      memwr_q    <= 1'b0;
    end else begin
      aluout_q   <= aluout_d;
      busb_q     <= busb_d;
      rw_q       <= rw_d;
      regwr_q    <= regwr_d;
      memtoreg_q <= memtoreg_d;
      memwr_q    <= memwr_d;
    end
  end

  assign MEM_ALUout   = aluout_q;
  assign MEM_busB     = busb_q;
  assign MEM_Rw       = rw_q;
  assign MEM_RegWr    = regwr_q;
  assign MEM_MemtoReg = memtoreg_q;
  assign MEM_MemWr    = memwr_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed literal cases plus a random
// instruction stream compared every cycle against an instruction-level model.
module tb_ex_stage;

  localparam int unsigned MC = 32;

  logic        Clk;
  logic        Rst;
  logic [31:0] EX_PC4, EX_Jtarg, EX_busA, EX_busB;
  logic [4:0]  EX_Rt, EX_Rd;
  logic [5:0]  EX_func;
  logic [15:0] EX_immd;
  logic        EX_RegWr, EX_ALUSrc, EX_RegDst, EX_MemtoReg, EX_MemWr;
  logic        EX_Branch, EX_Jump, EX_ExtOp, EX_R_type;
  logic [2:0]  EX_ALUop;
`ifdef EX_FWD_EN
  logic [4:0]  EX_Rs, WB_Rw;
  logic        WB_RegWr;
  logic [31:0] WB_busW;
`endif
  logic        PCSrc, Flush, Stall;
  logic [31:0] NextPC, MEM_ALUout, MEM_busB;
  logic [4:0]  MEM_Rw;
  logic        MEM_RegWr, MEM_MemtoReg, MEM_MemWr;

  ex_stage #(.MULT_CYCLES(MC)) dut (
    .Clk(Clk), .Rst(Rst), .EX_PC4(EX_PC4), .EX_Jtarg(EX_Jtarg),
    .EX_busA(EX_busA), .EX_busB(EX_busB), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd),
    .EX_func(EX_func), .EX_immd(EX_immd), .EX_RegWr(EX_RegWr),
    .EX_ALUSrc(EX_ALUSrc), .EX_RegDst(EX_RegDst), .EX_MemtoReg(EX_MemtoReg),
    .EX_MemWr(EX_MemWr), .EX_Branch(EX_Branch), .EX_Jump(EX_Jump),
    .EX_ExtOp(EX_ExtOp), .EX_R_type(EX_R_type), .EX_ALUop(EX_ALUop),
`ifdef EX_FWD_EN
    .EX_Rs(EX_Rs), .WB_Rw(WB_Rw), .WB_RegWr(WB_RegWr), .WB_busW(WB_busW),
`endif
    .PCSrc(PCSrc), .NextPC(NextPC), .Flush(Flush), .Stall(Stall),
    .MEM_ALUout(MEM_ALUout), .MEM_busB(MEM_busB), .MEM_Rw(MEM_Rw),
    .MEM_RegWr(MEM_RegWr), .MEM_MemtoReg(MEM_MemtoReg), .MEM_MemWr(MEM_MemWr)
  );

  initial Clk = 1'b1;
  always #5 Clk = ~Clk;

  int npass = 0;
  int ntotal = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- instruction-level model ----------------
  typedef enum {K_ADD, K_SUB, K_OR, K_AND, K_SLT, K_SLTU, K_LUI, K_HI, K_LO, K_MUL, K_BAD} kind_e;
  typedef struct {
    logic [31:0] res, a, b, npc;
    logic [4:0]  rw;
    logic        rw_en, pcsrc, stall, mult;
  } exp_t;

  logic [31:0] m_aluout, m_busB, m_hi, m_lo, m_pa, m_pb;
  logic [4:0]  m_rw;
  logic        m_regwr, m_memwr, m_memtoreg, m_psigned;
  int          m_cyc = 0;          // edges the current multiply has spent in EX
  logic        last_stall = 1'b0, last_pcsrc = 1'b0;

`ifdef EX_FWD_EN
  function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] v);
    if (m_regwr && m_rw != 0 && m_rw == src) return m_aluout;
    if (WB_RegWr && WB_Rw != 0 && WB_Rw == src) return WB_busW;
    return v;
  endfunction
`endif

  function automatic exp_t model_comb();
    exp_t e;
    kind_e k;
    logic [31:0] op2;
    int sx;
    e.a = EX_busA;
    e.b = EX_busB;
`ifdef EX_FWD_EN
    e.a = fwd(EX_Rs, EX_busA);
    e.b = fwd(EX_Rt, EX_busB);
`endif
    sx  = $signed(EX_immd);
    op2 = EX_ALUSrc ? (EX_ExtOp ? 32'(sx) : {16'h0, EX_immd}) : e.b;
    if (EX_R_type) begin
      case (EX_func)
        6'h20, 6'h21: k = K_ADD;
        6'h22, 6'h23: k = K_SUB;
        6'h24:        k = K_AND;
        6'h25:        k = K_OR;
        6'h2A:        k = K_SLT;
        6'h2B:        k = K_SLTU;
        6'h10:        k = K_HI;
        6'h12:        k = K_LO;
        6'h18, 6'h19: k = K_MUL;
        default:      k = K_BAD;
      endcase
    end else begin
      case (EX_ALUop)
        3'd1:    k = K_SUB;
        3'd2:    k = K_OR;
        3'd3:    k = K_AND;
        3'd4:    k = K_SLT;
        3'd5:    k = K_SLTU;
        3'd6:    k = K_LUI;
        default: k = K_ADD;
      endcase
    end
    case (k)
      K_ADD:   e.res = e.a + op2;
      K_SUB:   e.res = e.a - op2;
      K_OR:    e.res = e.a | op2;
      K_AND:   e.res = e.a & op2;
      K_SLT:   e.res = (int'(e.a) < int'(op2)) ? 32'd1 : 32'd0;
      K_SLTU:  e.res = (e.a < op2) ? 32'd1 : 32'd0;
      K_LUI:   e.res = op2 * 32'd65536;
      K_HI:    e.res = m_hi;
      K_LO:    e.res = m_lo;
      default: e.res = 32'd0;
    endcase
    e.rw_en = EX_RegWr && (k != K_BAD);
    e.rw    = EX_RegDst ? EX_Rd : EX_Rt;
    e.mult  = (k == K_MUL);
    e.stall = e.mult && (m_cyc <= MC);
    e.pcsrc = EX_Jump || (EX_Branch && e.a == e.b);
    e.npc   = EX_Jump ? EX_Jtarg : EX_PC4 + 32'(sx * 4);
    return e;
  endfunction

  task automatic commit();
    exp_t e;
    e = model_comb();
    if (Rst) begin
      m_aluout = 0; m_busB = 0; m_rw = 0; m_regwr = 0; m_memwr = 0; m_memtoreg = 0;
      m_hi = 0; m_lo = 0; m_cyc = 0; last_stall = 0; last_pcsrc = 0;
      return;
    end
    last_stall = e.stall;
    last_pcsrc = e.pcsrc;
    if (e.mult && m_cyc == 0) begin
      m_pa = e.a; m_pb = e.b; m_psigned = (EX_func == 6'h18);
    end
    if (e.mult || e.stall) begin
      m_aluout = 0; m_busB = 0; m_rw = 0; m_regwr = 0; m_memwr = 0; m_memtoreg = 0;
    end else begin
      m_aluout = e.res; m_busB = e.b; m_rw = e.rw; m_regwr = e.rw_en;
      m_memwr = EX_MemWr; m_memtoreg = EX_MemtoReg;
    end
    if (e.mult && m_cyc == MC) begin
      if (m_psigned) {m_hi, m_lo} = 64'(longint'($signed(m_pa)) * longint'($signed(m_pb)));
      else           {m_hi, m_lo} = {32'h0, m_pa} * {32'h0, m_pb};
    end
    m_cyc = (e.mult && e.stall) ? m_cyc + 1 : 0;
  endtask

  // Every-cycle comparison of DUT outputs against the model
  always @(posedge Clk) begin : cmp
    exp_t e;
    if (chk_en && !Rst) begin
      e = model_comb();
      chk("Stall", 32'(Stall), 32'(e.stall));
      chk("PCSrc", 32'(PCSrc), 32'(e.pcsrc));
      chk("Flush", 32'(Flush), 32'(e.pcsrc));
      if (e.pcsrc) chk("NextPC", NextPC, e.npc);
      chk("MEM_ALUout", MEM_ALUout, m_aluout);
      chk("MEM_busB", MEM_busB, m_busB);
      chk("MEM_Rw", 32'(MEM_Rw), 32'(m_rw));
      chk("MEM_RegWr", 32'(MEM_RegWr), 32'(m_regwr));
      chk("MEM_MemWr", 32'(MEM_MemWr), 32'(m_memwr));
      chk("MEM_MemtoReg", 32'(MEM_MemtoReg), 32'(m_memtoreg));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycle();
    @(negedge Clk);
    commit();
    #1;
  endtask

  task automatic drive_nop();
    EX_PC4 = 0; EX_Jtarg = 0; EX_busA = 0; EX_busB = 0; EX_Rt = 0; EX_Rd = 0;
    EX_func = 0; EX_immd = 0; EX_RegWr = 0; EX_ALUSrc = 0; EX_RegDst = 0;
    EX_MemtoReg = 0; EX_MemWr = 0; EX_Branch = 0; EX_Jump = 0; EX_ExtOp = 0;
    EX_R_type = 0; EX_ALUop = 0;
`ifdef EX_FWD_EN
    EX_Rs = 0; WB_Rw = 0; WB_RegWr = 0; WB_busW = 0;
`endif
  endtask

  task automatic set_r(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    drive_nop();
    EX_R_type = 1; EX_func = f; EX_busA = a; EX_busB = b;
    EX_Rd = rd; EX_RegDst = 1; EX_RegWr = 1;
  endtask

  function automatic logic [31:0] rand_val();
    logic [31:0] corners [5] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  task automatic rand_instr();
    logic [5:0] ft [12] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                            6'h2A, 6'h2B, 6'h18, 6'h19, 6'h10, 6'h12};
    int kind;
    drive_nop();
    kind = $urandom_range(0, 7);
    EX_PC4 = $urandom & 32'hFFFF_FFFC; EX_Jtarg = $urandom;
    EX_busA = rand_val(); EX_busB = rand_val();
    EX_Rt = 5'($urandom_range(0, 7)); EX_Rd = 5'($urandom_range(0, 7));
    EX_immd = 16'($urandom); EX_ExtOp = 1'($urandom);
    EX_MemWr = 1'($urandom); EX_MemtoReg = 1'($urandom);
`ifdef EX_FWD_EN
    EX_Rs = 5'($urandom_range(0, 7)); WB_Rw = 5'($urandom_range(0, 7));
    WB_RegWr = 1'($urandom); WB_busW = $urandom;
`endif
    case (kind)
      0, 1, 2: begin
        EX_R_type = 1; EX_RegDst = 1; EX_RegWr = 1;
        EX_func = ($urandom_range(0, 12) == 0) ? 6'($urandom) : ft[$urandom_range(0, 11)];
      end
      3, 4: begin
        EX_ALUSrc = 1; EX_RegWr = 1; EX_ALUop = 3'($urandom);
      end
      5: begin
        EX_Branch = 1; EX_ALUop = 3'd1;
        if ($urandom_range(0, 1) == 0) EX_busB = EX_busA;
      end
      6: begin
        EX_Jump = 1; EX_Branch = 1'($urandom);
        if ($urandom_range(0, 1) == 0) EX_busB = EX_busA;
      end
      default: begin
        EX_R_type = 1; EX_RegDst = 1; EX_RegWr = 1;
        EX_func = ($urandom_range(0, 1) == 0) ? 6'h10 : 6'h12;
      end
    endcase
  endtask

  // Holds a multiply in EX until Stall drops; returns the stalled-cycle count
  task automatic run_mult(input string tag, output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (Stall !== 1'b1) break;
      n++;
      if (k > 0) chk({tag, "_no_regwr"}, 32'(MEM_RegWr), 32'd0);
      cycle();
    end
    cycle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    drive_nop();
    Rst = 1;
    cycle();
    cycle();
    Rst = 0;
    chk_en = 1;

    // reset state
    chk("rst_aluout", MEM_ALUout, 32'd0);
    chk("rst_regwr", 32'(MEM_RegWr), 32'd0);
    chk("rst_stall", 32'(Stall), 32'd0);

    // R-type add
    set_r(6'h20, 32'd7, 32'd5, 5'd3);
    cycle();
    chk("add_out", MEM_ALUout, 32'd12);
    chk("add_rw", 32'(MEM_Rw), 32'd3);
    chk("add_regwr", 32'(MEM_RegWr), 32'd1);

    // subtraction wraps; invalid func suppresses the write
    set_r(6'h22, 32'd0, 32'd1, 5'd4);
    cycle();
    chk("sub_wrap", MEM_ALUout, 32'hFFFF_FFFF);
    set_r(6'h3F, 32'd9, 32'd9, 5'd6);
    cycle();
    chk("bad_func_out", MEM_ALUout, 32'd0);
    chk("bad_func_regwr", 32'(MEM_RegWr), 32'd0);

    // lui through the immediate path
    drive_nop();
    EX_ALUop = 3'b110; EX_ALUSrc = 1; EX_immd = 16'h1234; EX_RegWr = 1; EX_Rt = 5'd7;
    cycle();
    chk("lui_out", MEM_ALUout, 32'h1234_0000);
    chk("lui_rw", 32'(MEM_Rw), 32'd7);

    // beq taken / not taken
    drive_nop();
    EX_Branch = 1; EX_busA = 9; EX_busB = 9; EX_PC4 = 32'h100; EX_immd = 16'hFFFF;
    #1;
    chk("beq_pcsrc", 32'(PCSrc), 32'd1);
    chk("beq_flush", 32'(Flush), 32'd1);
    chk("beq_target", NextPC, 32'h0000_00FC);
    EX_busB = 8;
    #1;
    chk("beq_not_taken", 32'(PCSrc), 32'd0);
    cycle();

    // jump beats a taken branch
    drive_nop();
    EX_Jump = 1; EX_Branch = 1; EX_busA = 3; EX_busB = 3; EX_Jtarg = 32'h400;
    #1;
    chk("jump_target", NextPC, 32'h0000_0400);
    cycle();

    // signed mult -3 * 4, then mflo / mfhi
    set_r(6'h18, 32'hFFFF_FFFD, 32'd4, 5'd5);
    run_mult("mult", n);
    chk("mult_stall_cycles", 32'(n), 32'd33);
    set_r(6'h12, 0, 0, 5'd8);
    cycle();
    chk("mflo_after_mult", MEM_ALUout, 32'hFFFF_FFF4);
    set_r(6'h10, 0, 0, 5'd9);
    cycle();
    chk("mfhi_after_mult", MEM_ALUout, 32'hFFFF_FFFF);

    // unsigned multu 0xFFFFFFFF * 2
    set_r(6'h19, 32'hFFFF_FFFF, 32'd2, 5'd5);
    run_mult("multu", n);
    chk("multu_stall_cycles", 32'(n), 32'd33);
    set_r(6'h10, 0, 0, 5'd9);
    cycle();
    chk("mfhi_multu", MEM_ALUout, 32'd1);
    set_r(6'h12, 0, 0, 5'd9);
    cycle();
    chk("mflo_multu", MEM_ALUout, 32'hFFFF_FFFE);

    // reset while the multiplier is at count 10
    set_r(6'h19, 32'd5, 32'd7, 5'd5);
    for (int k = 0; k < 11; k++) cycle();
    Rst = 1;
    drive_nop();
    cycle();
    Rst = 0;
    #1;
    chk("rst_busy_stall", 32'(Stall), 32'd0);
    chk("rst_busy_aluout", MEM_ALUout, 32'd0);
    chk("rst_busy_regwr", 32'(MEM_RegWr), 32'd0);
    set_r(6'h10, 0, 0, 5'd9);
    cycle();
    chk("rst_busy_hi", MEM_ALUout, 32'd0);
    set_r(6'h12, 0, 0, 5'd9);
    cycle();
    chk("rst_busy_lo", MEM_ALUout, 32'd0);

`ifdef EX_FWD_EN
    // EX/MEM forward beats MEM/WB; register 0 is never forwarded
    set_r(6'h20, 32'd10, 32'd20, 5'd2);
    cycle();
    set_r(6'h22, 32'd111, 32'd4, 5'd3);
    EX_Rs = 2; EX_Rt = 1; WB_Rw = 2; WB_RegWr = 1; WB_busW = 32'd999;
    cycle();
    chk("fwd_exmem_priority", MEM_ALUout, 32'd26);
    set_r(6'h20, 32'd5, 32'd5, 5'd0);
    cycle();
    set_r(6'h20, 32'd3, 32'd1, 5'd4);
    EX_Rs = 0; EX_Rt = 1; WB_Rw = 0; WB_RegWr = 1; WB_busW = 32'd77;
    cycle();
    chk("fwd_r0_ignored", MEM_ALUout, 32'd4);
`endif

    // random instruction stream; the bench acts as ID/EX (hold on stall, bubble on flush)
    drive_nop();
    cycle();
    for (int i = 0; i < 300; i++) begin
      if (last_pcsrc) drive_nop();
      else if (!last_stall) rand_instr();
      cycle();
    end

    chk_en = 0;
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. Consumes the ID/EX pipeline register outputs (EX_*) and produces the EX/MEM pipeline register outputs (MEM_*).
- Contains:
  - ALU control decode and the ALU itself.
  - Immediate extension.
  - Branch/jump resolution with flush request.
  - Iterative 32-cycle shift-add multiplier with HI/LO registers and a stall request.
  - The EX/MEM register.

Parameters:
- MULT_CYCLES, 32, iterations of the shift-add multiplier; must equal the operand width.

Ports:
- Clk  in  1  clock; all state updates on negedge Clk, matching the other pipeline registers.
- Rst  in  1  synchronous, active-high reset.
- EX_PC4  in  32  PC+4 of the instruction in EX.
- EX_Jtarg  in  32  jump target.
- EX_busA, EX_busB  in  32 each  register operands.
- EX_Rt, EX_Rd  in  5 each  register numbers.
- EX_func  in  6  function field.
- EX_immd  in  16  immediate.
- EX_RegWr, EX_ALUSrc, EX_RegDst, EX_MemtoReg, EX_MemWr, EX_Branch, EX_Jump, EX_ExtOp, EX_R_type  in  1 each  control bits.
- EX_ALUop  in  3  ALU opcode.
- PCSrc  out  1  redirect fetch this cycle (combinational).
- NextPC  out  32  redirect target (combinational).
- Flush  out  1  clear IF/ID and ID/EX at the next edge (equals PCSrc).
- Stall  out  1  hold PC, IF/ID and ID/EX at the next edge.
- MEM_ALUout  out  32  registered ALU result.
- MEM_busB  out  32  registered store data.
- MEM_Rw  out  5  registered destination register.
- MEM_RegWr, MEM_MemtoReg, MEM_MemWr  out  1 each  registered controls.

Behaviour:
- Reset (Rst=1 at a negedge):
  - All MEM_* outputs clear to 0.
  - HI and LO clear to 0.
  - Multiplier FSM goes to IDLE with count 0.
  - Any multiply in progress is abandoned with no HI/LO write.
- Immediate extension: sign-extend when EX_ExtOp=1, otherwise zero-extend. ALU operand B = extended immediate when EX_ALUSrc=1, otherwise EX_busB.
- ALU op, non-R-type (EX_ALUop): 000 add, 001 sub, 010 or, 011 and, 100 slt, 101 sltu, 110 lui (B<<16), 111 add.
- ALU op, R-type (EX_func):
  - add/addu 100000/100001
  - sub/subu 100010/100011
  - and 100100, or 100101
  - slt 101010, sltu 101011
  - mfhi 010000 (result = HI), mflo 010010 (result = LO)
  - mult 011000, multu 011001
  - Any other func: result 0, RegWr forced to 0.
- All arithmetic wraps modulo 2^32; no overflow trap.
- Destination: Rw = EX_Rd when EX_RegDst=1, else EX_Rt.
- Branch: taken when EX_Branch=1 and busA==busB. Branch target = EX_PC4 + (sext(immd)<<2), computed modulo 2^32.
- Jump: EX_Jump=1 gives NextPC = EX_Jtarg. Jump has priority over branch.
- PCSrc = taken | jump, driven in the same cycle.
- Multiplier FSM:
  - States: IDLE, BUSY, DONE.
  - IDLE + mult/multu in EX: latch operand magnitudes and sign flag (signed only); count=0; go to BUSY; Stall=1.
  - BUSY: one add/shift per cycle; Stall=1. At count==MULT_CYCLES-1, write the 64-bit product (negated if the sign flag is set) to HI:LO and go to DONE.
  - DONE: Stall=0; the mult still in EX is not restarted; go to IDLE.
  - Result: a mult occupies EX for MULT_CYCLES+2 cycles.
  - Stall = (IDLE & is_mult) | BUSY.
- EX/MEM register:
  - Stall=1, or a mult/multu in EX: load a bubble (RegWr=0, MemWr=0, MemtoReg=0; data fields don't-care, cleared to 0).
  - Otherwise: load the computed values.
  - A branch/jump in EX writes its own EX/MEM entry normally (RegWr as decoded).
- Simultaneous events:
  - Rst beats everything.
  - Flush and Stall are never both asserted: branch/jump are not mult.
- mfhi/mflo directly following a mult reads the new HI/LO, because the mult holds EX until DONE.

Optional Feature:
- Macro: EX_FWD_EN.
- Defined, adds these ports:
  - EX_Rs  in  5
  - WB_Rw  in  5
  - WB_RegWr  in  1
  - WB_busW  in  32
- Forwarding for operands A (Rs) and B (Rt):
  - EX/MEM forward when MEM_RegWr & MEM_Rw!=0 & MEM_Rw==src.
  - Else MEM/WB forward when WB_RegWr & WB_Rw!=0 & WB_Rw==src.
  - EX/MEM has priority over MEM/WB.
  - Forwarded values feed the ALU, the branch compare, the multiplier and MEM_busB.
- Undefined: EX_busA/EX_busB are used unmodified; the ports above are absent.

Decomposition:
- Package ex_pkg:
  - ALUop constants, R-type func constants, mult FSM state enum.
  - Ctrl/data widths: 32 data, 5 regnum.
- One sub-module: mult_unit, covering the FSM, the shift-add datapath and HI/LO, with ports start, signed_op, a, b, stall, hi, lo.
- ALU stays inline.

Test Plan:
- R-type add, busA=7, busB=5, Rd=3, RegDst=1 -> next negedge MEM_ALUout=12, MEM_Rw=3, MEM_RegWr=1.
- beq, busA=busB=9, PC4=0x100, immd=0xFFFF -> PCSrc=Flush=1, NextPC=0xFC; beq with busA!=busB -> PCSrc=0.
- mult, A=-3, B=4 -> Stall high for 33 cycles, HI=0xFFFFFFFF, LO=0xFFFFFFF4; following mflo -> MEM_ALUout=0xFFFFFFF4.
- multu, A=0xFFFFFFFF, B=2 -> HI=1, LO=0xFFFFFFFE; no MEM_RegWr for the mult itself.
- Rst asserted at BUSY count 10 -> next negedge FSM IDLE, Stall=0, HI=LO=0, MEM_*=0.
- EX_FWD_EN: add r2 then sub using r2, with MEM_Rw=2 and WB_Rw=2 both writing -> EX/MEM value used; Rs=0 is never forwarded.
